// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO plus launch FSM feeding a UART transmitter's
//             tx_ena/tx_data, paced on the UART's registered tx_busy.
//             Optional synchronous flush input: UART_TX_FIFO_FLUSH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int D_WIDTH    = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [D_WIDTH-1:0]    wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    input  logic                  uart_tx_busy,
    output logic                  uart_tx_ena,
    output logic [D_WIDTH-1:0]    uart_tx_data,
    output logic                  tx_idle
`ifdef UART_TX_FIFO_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    logic [D_WIDTH-1:0]    mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic                  tx_ena_q, tx_ena_d;
    logic [D_WIDTH-1:0]    tx_data_q, tx_data_d;
    state_t                state_q, state_d;

    logic                  flush_req;
    logic                  push;
    logic                  pop;
    logic                  push_drop;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Flush wins over both a push and a launch pop in the same cycle.
    assign push      = wr_en && !full_q && !flush_req;
    assign push_drop = wr_en && full_q && !flush_req;
    assign pop       = (state_q == S_IDLE) && !empty_q && !uart_tx_busy && !flush_req;

    // FIFO bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end

        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
    end

    // Launch FSM with registered strobe and data
    always_comb begin
        state_d   = state_q;
        tx_ena_d  = 1'b0;
        tx_data_d = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    tx_ena_d  = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_ena_q   <= 1'b0;
            tx_data_q  <= '0;
            state_q    <= S_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            tx_ena_q   <= tx_ena_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by level and the pointers.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign uart_tx_ena  = tx_ena_q;
    assign uart_tx_data = tx_data_q;
    assign tx_idle      = empty_q && (state_q == S_IDLE) && !uart_tx_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed self-checking bench for uart_tx_fifo with a simple
//             UART busy model. Flush steps need UART_TX_FIFO_FLUSH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       full, empty, overflow, uart_tx_ena, tx_idle;
    logic [4:0] level;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic       flush = 1'b0;
`endif

    // UART model: busy rises the cycle after it samples ena, held hold_len cycles
    logic       hold_busy = 1'b1;
    logic       mbusy     = 1'b0;
    int         mcnt      = 0;
    int         hold_len  = 20;
    logic       prev_ena  = 1'b0;
    int         dbl_ena   = 0;
    logic [7:0] launched[$];
    logic [7:0] exp_q[$];

    assign uart_tx_busy = hold_busy | mbusy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    uart_tx_fifo #(.D_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_ena  (uart_tx_ena),
        .uart_tx_data (uart_tx_data),
        .tx_idle      (tx_idle)
`ifdef UART_TX_FIFO_FLUSH_EN
        ,
        .flush        (flush)
`endif
    );

    always @(posedge clk) begin
        if (uart_tx_ena) begin
            launched.push_back(uart_tx_data);
            mbusy <= 1'b1;
            mcnt  <= hold_len;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt  <= 0;
            mbusy <= 1'b0;
        end
        if (uart_tx_ena && prev_ena) begin
            dbl_ena <= dbl_ena + 1;
        end
        prev_ena <= uart_tx_ena;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!tx_idle && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(tx_idle), 32'd1);
    endtask

    task automatic wait_mbusy(input string tag, input int budget);
        int n = 0;
        while (!mbusy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(mbusy), 32'd1);
    endtask

    int n0;

    initial begin
        // Reset with UART reporting busy
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick();
        check("rst_level",    32'(level),        32'd0);
        check("rst_empty",    32'(empty),        32'd1);
        check("rst_full",     32'(full),         32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
        check("rst_ena",      32'(uart_tx_ena),  32'd0);
        check("rst_data",     32'(uart_tx_data), 32'd0);
        check("rst_txidle_busy", 32'(tx_idle),   32'd0);
        tick(5);
        check("rst_no_launch", 32'(launched.size()), 32'd0);
        hold_busy = 1'b0;
        tick();
        check("rst_txidle", 32'(tx_idle), 32'd1);

        // Single byte latency
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("e0_empty", 32'(empty),       32'd0);
        check("e0_level", 32'(level),       32'd1);
        check("e0_ena",   32'(uart_tx_ena), 32'd0);
        tick();
        check("e1_ena",   32'(uart_tx_ena),  32'd1);
        check("e1_data",  32'(uart_tx_data), 32'hA5);
        check("e1_level", 32'(level),        32'd0);
        check("e1_empty", 32'(empty),        32'd1);
        tick();
        check("e2_ena",   32'(uart_tx_ena),  32'd0);
        check("e2_busy",  32'(uart_tx_busy), 32'd1);
        check("e2_txidle", 32'(tx_idle),     32'd0);
        exp_q.push_back(8'hA5);
        wait_idle("single_idle", 100);
        check("single_count", 32'(launched.size()), 32'd1);

        // Fill to DEPTH while busy, then overflow
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        check("fill_full",  32'(full),  32'd1);
        check("fill_level", 32'(level), 32'd16);
        push(8'h11);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_level", 32'(level),    32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        hold_len  = 3;
        hold_busy = 1'b0;
        wait_idle("drain16_idle", 1000);
        check("drain16_count", 32'(launched.size()), 32'd17);
        check("drain16_empty", 32'(empty), 32'd1);

        // Full FIFO: push coinciding with a launch pop is dropped
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h20 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        check("full2", 32'(full), 32'd1);
        wr_en = 1'b1; wr_data = 8'h30; hold_busy = 1'b0;
        tick();
        wr_en = 1'b0; hold_busy = 1'b1;
        check("popdrop_ovf",   32'(overflow),     32'd1);
        check("popdrop_level", 32'(level),        32'd15);
        check("popdrop_full",  32'(full),         32'd0);
        check("popdrop_ena",   32'(uart_tx_ena),  32'd1);
        check("popdrop_data",  32'(uart_tx_data), 32'h20);
        push(8'h31);
        exp_q.push_back(8'h31);
        check("refill_level", 32'(level), 32'd16);
        wr_en = 1'b1; wr_data = 8'h32; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_over_clr", 32'(overflow), 32'd1);
        check("ovf_set_level",    32'(level),    32'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr2", 32'(overflow), 32'd0);
        hold_busy = 1'b0;
        wait_idle("drain2_idle", 1000);
        check("drain2_count", 32'(launched.size()), 32'd34);

        // Reset during WAIT_DONE
        hold_len  = 20;
        hold_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h40 + i));
        end
        exp_q.push_back(8'h40);
        hold_busy = 1'b0;
        wait_mbusy("rstmid_busy", 50);
        tick(3);
        check("rstmid_level_pre", 32'(level), 32'd7);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstmid_level", 32'(level),       32'd0);
        check("rstmid_ena",   32'(uart_tx_ena), 32'd0);
        check("rstmid_empty", 32'(empty),       32'd1);
        n0 = launched.size();
        wait_idle("rstmid_idle", 200);
        tick(10);
        check("rstmid_no_launch", 32'(launched.size()), 32'(n0));
        check("rstmid_count",     32'(n0),              32'd35);

`ifdef UART_TX_FIFO_FLUSH_EN
        // Flush during WAIT_DONE: in-flight byte completes, rest discarded
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h50 + i));
        end
        exp_q.push_back(8'h50);
        hold_busy = 1'b0;
        wait_mbusy("flush_busy", 50);
        tick(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level",  32'(level),        32'd0);
        check("flush_empty",  32'(empty),        32'd1);
        check("flush_busy2",  32'(uart_tx_busy), 32'd1);
        check("flush_txidle", 32'(tx_idle),      32'd0);
        wait_idle("flush_idle", 200);
        tick(10);
        check("flush_count", 32'(launched.size()), 32'd36);
`endif

        // Launched byte stream against the expected order
        check("seq_size", 32'(launched.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < launched.size()) begin
                check($sformatf("seq[%0d]", i), 32'(launched[i]), 32'(exp_q[i]));
            end
        end
        check("ena_single_cycle", 32'(dbl_ena), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer and launcher directly upstream of the UART core's transmitter.
- CPU/bus side pushes bytes into a synchronous FIFO.
- Launch FSM pops one byte at a time and drives the UART's tx_ena/tx_data, pacing on its registered tx_busy.
- Decouples software writes from the bit-serial line rate.

Parameters:
- D_WIDTH, 8: byte width; must match the UART core's D_WIDTH.
- ADDR_WIDTH, 4: FIFO address width; DEPTH = 2**ADDR_WIDTH entries (default 16).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- wr_en  in  1  push request, one byte per cycle.
- wr_data  in  D_WIDTH  byte to push.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  ADDR_WIDTH+1  current entry count, 0..DEPTH.
- overflow  out  1  sticky flag: a push was dropped.
- ovf_clr  in  1  clears overflow.
- uart_tx_busy  in  1  UART core tx_busy (registered; reads 1 out of UART reset).
- uart_tx_ena  out  1  one-cycle launch strobe to UART core.
- uart_tx_data  out  D_WIDTH  byte to UART core; valid while uart_tx_ena=1.
- tx_idle  out  1  FIFO empty, FSM in IDLE and uart_tx_busy=0.
- flush  in  1  only present with UART_TX_FIFO_FLUSH_EN.

Behaviour:
- All state is updated on rising clk only; no asynchronous paths.
- Reset (reset_n=0 at an edge):
  - wr_ptr, rd_ptr and level = 0.
  - empty=1, full=0, overflow=0.
  - uart_tx_ena=0, uart_tx_data=0, FSM=IDLE.
  - Reset mid-operation discards all buffered bytes and aborts any WAIT state.
  - A byte already handed to the UART is not recalled; the UART has its own reset.
- FIFO:
  - Circular buffer of DEPTH entries; wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH.
  - level is a separate counter, not derived from the pointers.
  - full = (level==DEPTH); empty = (level==0). Both are registered and consistent with level in the same cycle.
- Push:
  - wr_en=1 and full=0: store wr_data, advance wr_ptr, level+1.
  - wr_en=1 and full=1: byte dropped, pointers unchanged, overflow<=1. This holds even if a pop occurs in the same cycle.
- Pop: occurs only on the IDLE->LAUNCH transition and advances rd_ptr.
- Simultaneous accepted push and pop: level unchanged, both pointers advance.
- overflow:
  - Set has priority over ovf_clr when both happen in one cycle.
  - Otherwise ovf_clr=1 clears it.
- Launch FSM (registered outputs):
  - IDLE: if empty=0 and uart_tx_busy=0, then uart_tx_data<=mem[rd_ptr], uart_tx_ena<=1, pop, go to LAUNCH.
  - LAUNCH: uart_tx_ena<=0, go to WAIT_ACK. uart_tx_ena is high for exactly one cycle.
  - WAIT_ACK: stay until uart_tx_busy=1, then go to WAIT_DONE. The UART raises busy the cycle after it samples tx_ena.
  - WAIT_DONE: stay until uart_tx_busy=0, then go to IDLE.
- Latency:
  - Push accepted at edge E0 into an empty FIFO with the UART idle: empty falls at E0, and uart_tx_ena is high from edge E1 to E2.
  - Back-to-back bytes: the next uart_tx_ena comes 1 cycle after the FSM observes uart_tx_busy falling.
- After reset the UART reports busy=1 until its first idle cycle; IDLE waits on this naturally, so no byte is launched early.
- tx_idle is combinational from registered state.

Optional Feature:
- Macro UART_TX_FIFO_FLUSH_EN.
- Defined:
  - flush input exists. flush=1 at an edge sets wr_ptr=rd_ptr=0, level=0, empty=1, full=0.
  - flush has priority over a simultaneous push, which is dropped without setting overflow, and over an IDLE->LAUNCH pop, which is suppressed.
  - FSM states LAUNCH, WAIT_ACK and WAIT_DONE are unaffected; the in-flight byte completes.
- Undefined: no flush port; FIFO is emptied only by pops or reset.

Test Plan:
- Reset, uart_tx_busy=1 for 5 cycles then 0 -> no uart_tx_ena; tx_idle=1 once busy=0; level=0, empty=1.
- Push 0xA5 with the UART model idle (busy rises 1 cycle after ena and is held 20 cycles) -> uart_tx_ena one cycle at E1 with uart_tx_data=0xA5; level 1->0; tx_idle=1 after busy falls.
- Push 0x01..0x10 back-to-back (16 bytes, DEPTH=16) while busy=1 -> full=1, level=16. Push 0x11 -> dropped, overflow=1. Release busy -> 0x01..0x10 launched in order, one ena per busy cycle.
- Full FIFO, push coinciding with IDLE->LAUNCH pop -> push dropped, overflow=1, level=15. ovf_clr plus another overflow in the same cycle -> overflow stays 1.
- Fill to 8 bytes, deassert reset_n during WAIT_DONE -> next cycle level=0, uart_tx_ena=0, FSM IDLE; no further launches.
- With UART_TX_FIFO_FLUSH_EN: 5 bytes queued, flush during WAIT_DONE -> level=0 next cycle; current byte completes; no further uart_tx_ena.
